alu_ctrl_stage: RTL

Registered, parametrised ALU-control stage sitting in the ID/EX boundary of the pipelined core. It decodes the 2-bit main-decoder `aluop` and the full 6-bit `funct` field into an ALU control word, registers it with a valid bit, and flags unmapped R-type codes. With the multiply feature compiled in, it sequences a multi-cycle multiply: it holds the control word and requests a pipeline stall until the multiply latency has elapsed.

---
 rtl/alu_ctrl_stage_if.sv | 27 ++
 rtl/alu_ctrl_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage_if.sv
// alu_ctrl_stage_if: bundles the ID-side request signals and the registered
// ALU-control results of alu_ctrl_stage. The master side is the ID/hazard
// logic that drives the request. The slave side is the stage itself.
interface alu_ctrl_stage_if #(
    parameter int CTL_W = 4
);
    logic             valid_in;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic             stall_in;
    logic             flush;
    logic [CTL_W-1:0] alu_ctl;
    logic             valid_out;
    logic             illegal;
    logic             stall_req;
    logic             mc_done;

    modport master (
        output valid_in, aluop, funct, stall_in, flush,
        input  alu_ctl, valid_out, illegal, stall_req, mc_done
    );

    modport slave (
        input  valid_in, aluop, funct, stall_in, flush,
        output alu_ctl, valid_out, illegal, stall_req, mc_done
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control decode at the ID/EX boundary.
// Decodes aluop/funct into an ALU control word, registers it with a valid
// bit, and flags unmapped R-type funct codes.
// Optional feature macro: ALUCTL_MULDIV_EN. When it is defined, funct 011000
// decodes as a multi-cycle multiply. A small IDLE/BUSY FSM then holds the
// control word and raises stall_req until MUL_LAT cycles have elapsed.
// When it is undefined, mult is illegal and stall_req/mc_done are tied low.
module alu_ctrl_stage #(
    parameter int CTL_W   = 4,
    parameter int MUL_LAT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ctrl_stage_if.slave bus
);

    // Reject parameter values the logic cannot honour.
    if (CTL_W < 4) begin : g_bad_ctl_w
        $error("alu_ctrl_stage: CTL_W must be >= 4");
    end
    if (MUL_LAT < 2) begin : g_bad_mul_lat
        $error("alu_ctrl_stage: MUL_LAT must be >= 2");
    end

    logic [3:0]       w_ctl;
    logic             w_illegal;
    logic             w_stall_req;
    logic             w_mc_done;
    logic             w_capture;

    logic [CTL_W-1:0] r_alu_ctl;
    logic             r_valid;
    logic             r_illegal;

`ifdef ALUCTL_MULDIV_EN
    localparam int CNT_W = $clog2(MUL_LAT);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_is_mult;
`endif

    // Decode aluop/funct into the 4-bit control code and the illegal flag.
    // NOTE: every output of a combinational block gets a default first.
    // Otherwise a path that leaves a signal unassigned infers a latch.
    always_comb begin
        w_ctl     = 4'b0000;
        w_illegal = 1'b0;
`ifdef ALUCTL_MULDIV_EN
        w_is_mult = 1'b0;
`endif
        case (bus.aluop)
            2'b00:   w_ctl = 4'b0010;
            2'b01:   w_ctl = 4'b0110;
            2'b11:   w_ctl = 4'b0001;
            default: begin
                case (bus.funct)
                    6'b100000: w_ctl = 4'b0010;
                    6'b100010: w_ctl = 4'b0110;
                    6'b100100: w_ctl = 4'b0000;
                    6'b100101: w_ctl = 4'b0001;
                    6'b100111: w_ctl = 4'b1100;
                    6'b101010: w_ctl = 4'b0111;
`ifdef ALUCTL_MULDIV_EN
                    6'b011000: begin
                        w_ctl     = 4'b1000;
                        w_is_mult = 1'b1;
                    end
`endif
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // A new instruction is accepted only when nothing kills or holds the stage.
    assign w_capture = !bus.flush && !bus.stall_in && !w_stall_req;

    // Pipeline register: flush kills the slot, stalls hold it, capture loads it.
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_ctl <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_alu_ctl <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            r_alu_ctl <= CTL_W'(w_ctl);
            r_valid   <= bus.valid_in;
            r_illegal <= bus.valid_in && w_illegal;
        end
    end

`ifdef ALUCTL_MULDIV_EN
    // Multiply FSM state and latency counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: the counter runs down even under stall_in. A mult captured
    // in the final cycle re-arms the FSM with no gap cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (bus.flush) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture && bus.valid_in && w_is_mult) begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_W'(MUL_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else if (w_capture && bus.valid_in && w_is_mult) begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_W'(MUL_LAT - 1);
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // FSM outputs depend on registered state only.
    always_comb begin
        w_stall_req = (r_state == ST_BUSY) && (r_cnt != '0);
        w_mc_done   = (r_state == ST_BUSY) && (r_cnt == '0);
    end
`else
    assign w_stall_req = 1'b0;
    assign w_mc_done   = 1'b0;
`endif

    assign bus.alu_ctl   = r_alu_ctl;
    assign bus.valid_out = r_valid;
    assign bus.illegal   = r_illegal;
    assign bus.stall_req = w_stall_req;
    assign bus.mc_done   = w_mc_done;

endmodule
